// File: rtl/tri_list_shader.sv
// Double-buffered list of flat-shaded triangles. Per pixel: edge functions, coverage,
// nearest-depth select. Fixed 3-cycle latency; the list swaps in at frame start.
module tri_list_shader #(
    parameter int                 NUM_TRIS = 4,
    parameter int                 COORD_W  = 9,
    parameter int                 DEPTH_W  = 8,
    parameter int                 COLOR_W  = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    localparam int                CNT_W    = $clog2(NUM_TRIS + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 tri_valid_in,
    output logic                 tri_ready_out,
    input  logic [6*COORD_W-1:0] tri_verts_in,
    input  logic [DEPTH_W-1:0]   tri_depth_in,
    input  logic [COLOR_W-1:0]   tri_color_in,
    input  logic                 obj_done_in,
    input  logic                 new_frame_in,
    input  logic [COORD_W-1:0]   hcount_in,
    input  logic [COORD_W-1:0]   vcount_in,
    input  logic                 pix_valid_in,
    output logic [COLOR_W-1:0]   color_out,
    output logic                 pix_valid_out,
    output logic [CNT_W-1:0]     tri_count_out
);

    localparam int D_W   = COORD_W + 1;
    localparam int P_W   = 2 * COORD_W + 3;
    localparam int A_W   = P_W + 2;
    localparam int IDX_W = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_TRIS);

    // state   | meaning
    // IDLE    | shadow list empty or untouched since the last swap
    // LOAD    | accepting triangle words into the shadow bank
    // PEND    | shadow list committed, waiting for new_frame_in to swap
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_swap;
    logic               r_rst_meta;
    logic               r_rst_n_s;
    logic               r_bank;
    logic               w_wr_bank;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [CNT_W-1:0]   r_shadow_cnt;
    logic [CNT_W-1:0]   r_active_cnt;

    logic [6*COORD_W-1:0] r_verts [2][NUM_TRIS];
    logic [DEPTH_W-1:0]   r_depth [2][NUM_TRIS];
    logic [COLOR_W-1:0]   r_color [2][NUM_TRIS];

    logic signed [D_W-1:0] w1_dx [NUM_TRIS][3];
    logic signed [D_W-1:0] w1_dy [NUM_TRIS][3];
    logic signed [D_W-1:0] w1_ex [NUM_TRIS][3];
    logic signed [D_W-1:0] w1_ey [NUM_TRIS][3];
    logic                  w1_en [NUM_TRIS];
    logic signed [D_W-1:0] r1_dx [NUM_TRIS][3];
    logic signed [D_W-1:0] r1_dy [NUM_TRIS][3];
    logic signed [D_W-1:0] r1_ex [NUM_TRIS][3];
    logic signed [D_W-1:0] r1_ey [NUM_TRIS][3];
    logic                  r1_en [NUM_TRIS];
    logic [DEPTH_W-1:0]    r1_depth [NUM_TRIS];
    logic [COLOR_W-1:0]    r1_color [NUM_TRIS];
    logic                  r1_valid;

    logic signed [P_W-1:0] w2_e    [NUM_TRIS][3];
    logic signed [A_W-1:0] w2_area [NUM_TRIS];
    logic                  w2_cov  [NUM_TRIS];
    logic                  r2_cov  [NUM_TRIS];
    logic [DEPTH_W-1:0]    r2_depth [NUM_TRIS];
    logic [COLOR_W-1:0]    r2_color [NUM_TRIS];
    logic                  r2_valid;

    logic                  w3_found;
    logic [DEPTH_W-1:0]    w3_depth;
    logic [COLOR_W-1:0]    w3_color;

    function automatic logic [COORD_W-1:0] vx(input logic [6*COORD_W-1:0] v, input int k);
        return v[(6 - 2*k)*COORD_W - 1 -: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] vy(input logic [6*COORD_W-1:0] v, input int k);
        return v[(5 - 2*k)*COORD_W - 1 -: COORD_W];
    endfunction

    function automatic logic signed [D_W-1:0] sdiff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst_meta <= 1'b0;
            r_rst_n_s  <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n_s  <= r_rst_meta;
        end
    end

    always_ff @(posedge clk_in or negedge r_rst_n_s) begin
        if (!r_rst_n_s) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                w_ready = r_rst_n_s && (r_shadow_cnt < MAX_CNT);
                if (obj_done_in) begin
                    w_state_nxt = ST_PEND;
                end else if (tri_valid_in && w_ready) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_PEND: begin
                if (new_frame_in) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept      = tri_valid_in && w_ready;
    assign w_wr_bank     = ~r_bank;
    assign w_wr_idx      = r_shadow_cnt[IDX_W-1:0];
    assign tri_ready_out = w_ready;
    assign tri_count_out = r_active_cnt;

    always_ff @(posedge clk_in or negedge r_rst_n_s) begin
        if (!r_rst_n_s) begin
            r_bank       <= 1'b0;
            r_shadow_cnt <= '0;
            r_active_cnt <= '0;
        end else if (w_swap) begin
            r_bank       <= ~r_bank;
            r_active_cnt <= r_shadow_cnt;
            r_shadow_cnt <= '0;
        end else if (w_accept) begin
            r_shadow_cnt <= r_shadow_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_verts[w_wr_bank][w_wr_idx] <= tri_verts_in;
            r_depth[w_wr_bank][w_wr_idx] <= tri_depth_in;
            r_color[w_wr_bank][w_wr_idx] <= tri_color_in;
        end
    end

    // S1: the only stage that reads the active bank, so a swap is pixel-exact.
    always_comb begin
        for (int t = 0; t < NUM_TRIS; t++) begin
            for (int k = 0; k < 3; k++) begin
                w1_dx[t][k] = sdiff(hcount_in, vx(r_verts[r_bank][t], k));
                w1_dy[t][k] = sdiff(vcount_in, vy(r_verts[r_bank][t], k));
                w1_ex[t][k] = sdiff(vx(r_verts[r_bank][t], (k + 1) % 3), vx(r_verts[r_bank][t], k));
                w1_ey[t][k] = sdiff(vy(r_verts[r_bank][t], (k + 1) % 3), vy(r_verts[r_bank][t], k));
            end
            w1_en[t] = (CNT_W'(t) < r_active_cnt);
        end
    end

    always_ff @(posedge clk_in) begin
        r1_dx <= w1_dx;
        r1_dy <= w1_dy;
        r1_ex <= w1_ex;
        r1_ey <= w1_ey;
        r1_en <= w1_en;
        for (int t = 0; t < NUM_TRIS; t++) begin
            r1_depth[t] <= r_depth[r_bank][t];
            r1_color[t] <= r_color[r_bank][t];
        end
    end

    // The three edge functions sum to twice the signed area, independent of the pixel.
    always_comb begin
        for (int t = 0; t < NUM_TRIS; t++) begin
            for (int k = 0; k < 3; k++) begin
                w2_e[t][k] = P_W'(r1_dx[t][k]) * P_W'(r1_ey[t][k])
                           - P_W'(r1_dy[t][k]) * P_W'(r1_ex[t][k]);
            end
            w2_area[t] = A_W'(w2_e[t][0]) + A_W'(w2_e[t][1]) + A_W'(w2_e[t][2]);
            w2_cov[t]  = r1_en[t] && (w2_area[t] != '0) &&
                         ((!w2_e[t][0][P_W-1] && !w2_e[t][1][P_W-1] && !w2_e[t][2][P_W-1]) ||
                          ((w2_e[t][0][P_W-1] || (w2_e[t][0] == '0)) &&
                           (w2_e[t][1][P_W-1] || (w2_e[t][1] == '0)) &&
                           (w2_e[t][2][P_W-1] || (w2_e[t][2] == '0))));
        end
    end

    always_ff @(posedge clk_in) begin
        r2_cov   <= w2_cov;
        r2_depth <= r1_depth;
        r2_color <= r1_color;
    end

    // Strict less-than keeps the lower index on a depth tie.
    always_comb begin
        w3_found = 1'b0;
        w3_depth = '0;
        w3_color = BG_COLOR;
        for (int t = 0; t < NUM_TRIS; t++) begin
            if (r2_cov[t] && (!w3_found || (r2_depth[t] < w3_depth))) begin
                w3_found = 1'b1;
                w3_depth = r2_depth[t];
                w3_color = r2_color[t];
            end
        end
    end

    always_ff @(posedge clk_in or negedge r_rst_n_s) begin
        if (!r_rst_n_s) begin
            r1_valid      <= 1'b0;
            r2_valid      <= 1'b0;
            pix_valid_out <= 1'b0;
            color_out     <= BG_COLOR;
        end else begin
            r1_valid      <= pix_valid_in;
            r2_valid      <= r1_valid;
            pix_valid_out <= r2_valid;
            color_out     <= r2_valid ? w3_color : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_tri_list_shader.sv
// Directed bench for tri_list_shader: list loading, commit/swap and pixel colour tables.
module tb_tri_list_shader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tri_valid;
    logic        tri_ready;
    logic [53:0] tri_verts;
    logic [7:0]  tri_depth;
    logic [7:0]  tri_color;
    logic        obj_done;
    logic        new_frame;
    logic [8:0]  hcount;
    logic [8:0]  vcount;
    logic        pix_valid;
    logic [7:0]  color;
    logic        pv_out;
    logic [2:0]  tri_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int y;
        int exp;
    } pix_vec_t;

    pix_vec_t pv [32];

    tri_list_shader #(
        .NUM_TRIS(4), .COORD_W(9), .DEPTH_W(8), .COLOR_W(8), .BG_COLOR(8'd0)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .tri_valid_in  (tri_valid),
        .tri_ready_out (tri_ready),
        .tri_verts_in  (tri_verts),
        .tri_depth_in  (tri_depth),
        .tri_color_in  (tri_color),
        .obj_done_in   (obj_done),
        .new_frame_in  (new_frame),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .pix_valid_in  (pix_valid),
        .color_out     (color),
        .pix_valid_out (pv_out),
        .tri_count_out (tri_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_tri(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3, input int d, input int c);
        int waited = 0;
        @(negedge clk);
        tri_verts = {9'(x1), 9'(y1), 9'(x2), 9'(y2), 9'(x3), 9'(y3)};
        tri_depth = 8'(d);
        tri_color = 8'(c);
        tri_valid = 1'b1;
        while (!tri_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("load_ready", tri_ready, 1);
        @(posedge clk);
        #1 tri_valid = 1'b0;
    endtask

    task automatic pulse(input logic done, input logic nf);
        @(negedge clk);
        obj_done  = done;
        new_frame = nf;
        @(negedge clk);
        obj_done  = 1'b0;
        new_frame = 1'b0;
    endtask

    task automatic commit(input int exp_count);
        pulse(1'b1, 1'b0);
        check("pend_ready", tri_ready, 0);
        pulse(1'b0, 1'b1);
        check("swap_count", tri_count, 32'(exp_count));
    endtask

    // Streams pv[lo..hi] back to back; each result is due three edges after its drive.
    task automatic run_pix(input int lo, input int hi);
        int n = hi - lo + 1;
        for (int c = 0; c < n + 3; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                check($sformatf("pix_color[%0d]", lo + c - 3), color, 32'(pv[lo + c - 3].exp));
                check("pix_valid_out", pv_out, 1);
            end
            if (c < n) begin
                hcount    = 9'(pv[lo + c].x);
                vcount    = 9'(pv[lo + c].y);
                pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_valid_out", pv_out, 0);
        check("idle_color_bg", color, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_acc;
        logic exp_rdy [6];

        pv[0]  = '{25, 25, 0};
        pv[1]  = '{25, 25, 200};
        pv[2]  = '{39, 39, 0};
        pv[3]  = '{20, 20, 200};
        pv[4]  = '{40, 20, 200};
        pv[5]  = '{30, 30, 200};
        pv[6]  = '{19, 25, 0};
        pv[7]  = '{25, 25, 200};
        pv[8]  = '{26, 22, 250};
        pv[9]  = '{21, 21, 100};
        pv[10] = '{44, 20, 250};
        pv[11] = '{46, 20, 0};
        pv[12] = '{26, 22, 250};
        pv[13] = '{26, 22, 100};
        pv[14] = '{44, 20, 250};
        pv[15] = '{21, 21, 100};
        pv[16] = '{12, 12, 10};
        pv[17] = '{32, 12, 11};
        pv[18] = '{52, 12, 12};
        pv[19] = '{72, 12, 13};
        pv[20] = '{92, 12, 0};
        pv[21] = '{112, 12, 0};
        pv[22] = '{12, 12, 10};
        pv[23] = '{25, 25, 0};
        pv[24] = '{25, 25, 200};
        pv[25] = '{12, 12, 0};
        pv[26] = '{25, 25, 150};
        pv[27] = '{15, 15, 0};
        pv[28] = '{39, 39, 0};
        pv[29] = '{20, 20, 150};
        pv[30] = '{30, 30, 150};
        pv[31] = '{40, 20, 150};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b1;
        tri_valid = 1'b0;
        tri_verts = '0;
        tri_depth = '0;
        tri_color = '0;
        obj_done  = 1'b0;
        new_frame = 1'b0;
        hcount    = '0;
        vcount    = '0;
        pix_valid = 1'b0;

        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", tri_ready, 0);
        check("rst_color", color, 0);
        check("rst_valid_out", pv_out, 0);
        check("rst_count", tri_count, 0);
        repeat (3) @(negedge clk);
        check("rst_ready_hold", tri_ready, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ready", tri_ready, 1);
        check("post_rst_count", tri_count, 0);
        run_pix(0, 0);

        // single triangle
        load_tri(20, 20, 20, 40, 40, 20, 30, 200);
        commit(1);
        run_pix(1, 7);

        // overlapping pair, then equal depths
        load_tri(20, 20, 20, 40, 40, 20, 50, 100);
        load_tri(25, 20, 25, 40, 45, 20, 10, 250);
        commit(2);
        run_pix(8, 12);
        load_tri(20, 20, 20, 40, 40, 20, 10, 100);
        load_tri(25, 20, 25, 40, 45, 20, 10, 250);
        commit(2);
        run_pix(13, 15);

        // NUM_TRIS+2 words with valid held high
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tri_verts = {9'(10 + 20*k), 9'd10, 9'(10 + 20*k), 9'd20, 9'(20 + 20*k), 9'd10};
            tri_depth = 8'd5;
            tri_color = 8'(10 + k);
            tri_valid = 1'b1;
            check($sformatf("ovf_ready[%0d]", k), tri_ready, 32'(exp_rdy[k]));
            if (tri_ready) n_acc++;
        end
        @(negedge clk);
        tri_valid = 1'b0;
        check("ovf_accepted", n_acc, 4);
        commit(4);
        run_pix(16, 21);

        // obj_done together with new_frame: commit only, swap on the next frame
        load_tri(20, 20, 20, 40, 40, 20, 30, 200);
        pulse(1'b1, 1'b1);
        check("same_cycle_count", tri_count, 4);
        check("same_cycle_pend", tri_ready, 0);
        run_pix(22, 23);
        pulse(1'b0, 1'b1);
        check("late_swap_count", tri_count, 1);
        run_pix(24, 25);
        pulse(1'b0, 1'b1);
        check("idle_frame_noswap", tri_count, 1);

        // degenerate line in front of a reverse-wound copy of the first triangle
        load_tri(10, 10, 20, 20, 30, 30, 1, 77);
        load_tri(20, 20, 40, 20, 20, 40, 30, 150);
        commit(2);
        run_pix(26, 31);

        // reset in the middle of a pixel stream
        @(negedge clk);
        hcount    = 9'd25;
        vcount    = 9'd25;
        pix_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("stream_color", color, 150);
        check("stream_valid", pv_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_color", color, 0);
        check("midrst_valid", pv_out, 0);
        check("midrst_count", tri_count, 0);
        check("midrst_ready", tri_ready, 0);
        repeat (3) @(negedge clk);
        check("midrst_ready_hold", tri_ready, 0);
        check("midrst_valid_hold", pv_out, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rerel_ready", tri_ready, 1);
        check("rerel_count", tri_count, 0);
        check("rerel_valid", pv_out, 1);
        check("rerel_color", color, 0);
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tri_list_shader.md
Name: tri_list_shader

Overview:
- Parametrised successor to the single fixed-triangle rasterizer path. Holds a double-buffered list of up to NUM_TRIS flat-shaded triangles, loaded over a valid/ready stream.
- For every scaled pixel coordinate, it selects the nearest covering triangle and outputs its colour with fixed 3-cycle latency.
- Sits between scale and the TMDS encoders. The list is committed by obj_done_in and made visible at the next new_frame_in.

Parameters:
- NUM_TRIS, 4: max triangles per frame list (>=1).
- COORD_W, 9: unsigned vertex/pixel coordinate width.
- DEPTH_W, 8: unsigned per-triangle depth width; smaller = nearer.
- COLOR_W, 8: colour width.
- BG_COLOR, 0: colour output when no triangle covers the pixel.

Ports:
- clk_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous active-low reset
- tri_valid_in  in  1  triangle word valid
- tri_ready_out  out  1  shadow list can accept
- tri_verts_in  in  6*COORD_W  {x1,y1,x2,y2,x3,y3}, x1 at MSB
- tri_depth_in  in  DEPTH_W  triangle depth
- tri_color_in  in  COLOR_W  triangle colour
- obj_done_in  in  1  single-cycle pulse: shadow list complete
- new_frame_in  in  1  single-cycle frame-start pulse
- hcount_in  in  COORD_W  scaled x
- vcount_in  in  COORD_W  scaled y
- pix_valid_in  in  1  coordinate valid
- color_out  out  COLOR_W  pixel colour
- pix_valid_out  out  1  pix_valid_in delayed 3 cycles
- tri_count_out  out  $clog2(NUM_TRIS+1)  active-bank triangle count

Behaviour:
- Reset (async assert, sync release) sets:
  - active and shadow counts to 0, FSM to IDLE.
  - color_out=BG_COLOR, pix_valid_out=0, tri_ready_out=0 while reset is asserted.
- Load FSM states: IDLE, LOAD, PEND.
  - IDLE/LOAD: tri_ready_out = (shadow_count<NUM_TRIS).
  - Accept on tri_valid_in && tri_ready_out: write to shadow[shadow_count], increment count, go to LOAD.
  - Full list: ready drops. Further words are not accepted and do not overwrite.
  - obj_done_in in IDLE/LOAD goes to PEND, and ready=0 from the next cycle. An accept in the same cycle as obj_done_in is included in the list.
  - obj_done_in in PEND is ignored.
  - PEND with new_frame_in: swap banks. The active list becomes the shadow list, active count = shadow count, shadow count = 0, go to IDLE.
  - new_frame_in in IDLE/LOAD: no swap; the shadow list is retained.
  - obj_done_in and new_frame_in in the same cycle: go to PEND only; the swap waits for the following new_frame_in.
  - obj_done_in with zero triangles commits an empty list, so the screen shows BG_COLOR.
- Pixel pipeline: fixed latency 3, fully pipelined, one pixel per cycle, no stalls.
  - S1: per triangle and edge, form signed (COORD_W+1)-bit differences (px-xa),(py-ya),(xb-xa),(yb-ya). Register them with depth, colour and enable (index<active count).
  - Active-bank data is read only in S1, so a swap affects only pixels sampled after the swap edge.
  - S2: per edge, E=(px-xa)*(yb-ya)-(py-ya)*(xb-xa), computed at full 2*COORD_W+3 width with no truncation.
  - S2 coverage: covered = enable && (all three E>=0 || all three E<=0). Either winding is accepted and edges are inclusive.
  - Zero-area triangles (all E==0 everywhere) are never covered: explicitly reject when the signed area is 0.
  - S3: minimum-depth select across covering triangles. On equal depth, the lower index wins. No cover gives BG_COLOR.
  - When pix_valid is 0 at S3, color_out=BG_COLOR. pix_valid_out tracks the pipeline.
- No overflow anywhere: all intermediates are sized to the maximum range.

Test Plan:
- Reset, then load tri (20,20),(20,40),(40,20) depth 30, colour 200, obj_done, new_frame → pixel (25,25) gives 200 three cycles later; (39,39) gives 0; vertex (20,20) gives 200.
- Load two overlapping tris, depths 50 (colour 100) and 10 (colour 250) → overlap pixel gives 250. With equal depths 10/10 → index 0 colour wins.
- Load NUM_TRIS+2 words with valid held high → ready drops after the 4th, tri_count_out=4 after swap, words 5–6 not drawn.
- obj_done and new_frame in the same cycle → tri_count_out unchanged. The next new_frame updates it; the old list is still displayed in between.
- Degenerate tri (10,10),(20,20),(30,30), plus clockwise and counter-clockwise versions of one triangle → degenerate never drawn; both windings identical.
- Stream pix_valid_in continuously, assert rst_n_in low mid-stream → outputs immediately BG/0, tri_count_out=0, ready=0 until release.
